// File: rtl/inst_rom_fetch.sv
// Loadable instruction memory with a valid/ready fetch channel, a fixed-latency
// pipeline, an in-order output FIFO, per-request error flags and redirect flush.
module inst_rom_fetch #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int LAT    = 1,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_inst,
    output logic [1:0]        rsp_err,
    input  logic              ld_en,
    input  logic [AW-1:0]     ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              flush
);

    localparam int FIFO_D     = LAT + 1;
    localparam int CW         = $clog2(LAT + 2);
    localparam int FIFO_SLOTS = 1 << CW;
    localparam logic [ADDR_W-1:0] LIMIT   = ADDR_W'(4 * DEPTH);
    localparam logic [CW:0]       CREDITS = (CW+1)'(LAT + 1);
    localparam logic [CW-1:0]     LAST    = CW'(FIFO_D - 1);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              ready_en;
    logic              accept;
    logic              pop;
    logic [AW-1:0]     fetch_idx;
    logic [1:0]        fetch_err;
    logic [DATA_W-1:0] fetch_inst;

    logic              push_valid;
    logic [DATA_W-1:0] push_inst;
    logic [1:0]        push_err;
    logic              stage_busy;

    logic [DATA_W-1:0] fifo_inst [FIFO_SLOTS];
    logic [1:0]        fifo_err  [FIFO_SLOTS];
    logic [CW-1:0]     wr_ptr;
    logic [CW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [CW:0]       inflight;

    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

    // Errors are resolved at acceptance so an erroring fetch carries a NOP down the pipe.
    assign fetch_idx  = req_addr[AW+1:2];
    assign fetch_err  = {req_addr >= LIMIT, req_addr[1:0] != 2'b00};
    assign fetch_inst = (fetch_err != 2'b00) ? '0 : mem[fetch_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    // Every accepted request already owns a FIFO slot, so nothing stalls downstream.
    assign inflight  = {1'b0, count} + {{CW{1'b0}}, stage_busy};
    assign req_ready = ready_en && !ld_en && !flush && (inflight < CREDITS);
    assign accept    = req_valid && req_ready;
    assign pop       = rsp_valid && rsp_ready;

    generate
        if (LAT == 2) begin : g_stage
            logic              stage_valid;
            logic [DATA_W-1:0] stage_inst;
            logic [1:0]        stage_err;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stage_valid <= 1'b0;
                    stage_inst  <= '0;
                    stage_err   <= 2'b00;
                end else begin
                    stage_valid <= accept && !flush;
                    if (accept) begin
                        stage_inst <= fetch_inst;
                        stage_err  <= fetch_err;
                    end
                end
            end

            assign push_valid = stage_valid;
            assign push_inst  = stage_inst;
            assign push_err   = stage_err;
            assign stage_busy = stage_valid;
        end else begin : g_direct
            assign push_valid = accept;
            assign push_inst  = fetch_inst;
            assign push_err   = fetch_err;
            assign stage_busy = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (push_valid) begin
            fifo_inst[wr_ptr] <= push_inst;
            fifo_err[wr_ptr]  <= push_err;
        end
    end

    // Flush drops both the buffered responses and any write landing this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_valid) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + CW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + CW'(1);
            end
            if (push_valid && !pop) begin
                count <= count + CW'(1);
            end else if (!push_valid && pop) begin
                count <= count - CW'(1);
            end
        end
    end

    assign rsp_valid = (count != '0);
    assign rsp_inst  = rsp_valid ? fifo_inst[rd_ptr] : '0;
    assign rsp_err   = rsp_valid ? fifo_err[rd_ptr] : 2'b00;

endmodule

// File: tb/tb_inst_rom_fetch.sv
// Directed bench for inst_rom_fetch; one instance per legal latency, both driven
// by the same stimulus while the checks look at the instance selected by lat.
module tb_inst_rom_fetch;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        rsp_ready;
    logic        ld_en;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;
    logic        flush;

    logic        req_ready1, req_ready2;
    logic        rsp_valid1, rsp_valid2;
    logic [31:0] rsp_inst1, rsp_inst2;
    logic [1:0]  rsp_err1, rsp_err2;

    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_inst;
    logic [1:0]  rsp_err;

    int lat;
    int vectors;
    int miscompares;

    logic [31:0] words [3];

    inst_rom_fetch #(.ADDR_W(32), .DATA_W(32), .DEPTH(32), .LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready1), .req_addr(req_addr),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_inst(rsp_inst1), .rsp_err(rsp_err1),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .flush(flush)
    );

    inst_rom_fetch #(.ADDR_W(32), .DATA_W(32), .DEPTH(32), .LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready2), .req_addr(req_addr),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_inst(rsp_inst2), .rsp_err(rsp_err2),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .flush(flush)
    );

    assign req_ready = (lat == 2) ? req_ready2 : req_ready1;
    assign rsp_valid = (lat == 2) ? rsp_valid2 : rsp_valid1;
    assign rsp_inst  = (lat == 2) ? rsp_inst2  : rsp_inst1;
    assign rsp_err   = (lat == 2) ? rsp_err2   : rsp_err1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s (LAT=%0d): observed %h expected %h", tag, lat, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [4:0] idx, input logic [31:0] data);
        ld_en   = 1'b1;
        ld_addr = idx;
        ld_data = data;
        tick();
        ld_en   = 1'b0;
    endtask

    // Issues one request and returns in the cycle its response is due.
    task automatic applyStimulus(input logic [31:0] addr);
        req_valid = 1'b1;
        req_addr  = addr;
        #1;
        checkOutput("fetch_req_ready", {31'b0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        repeat (lat - 1) tick();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        words[0] = 32'h3c010001;
        words[1] = 32'h3c020002;
        words[2] = 32'h00411422;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        rsp_ready = 1'b0;
        ld_en     = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;
        flush     = 1'b0;

        for (int l = 1; l <= 2; l++) begin
            lat = l;
            rst_n = 1'b0;
            req_valid = 1'b0;
            rsp_ready = 1'b0;
            tick();
            tick();
            checkOutput("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
            checkOutput("reset_req_ready", {31'b0, req_ready}, 32'd0);
            checkOutput("reset_rsp_inst", rsp_inst, 32'd0);
            checkOutput("reset_rsp_err", {30'b0, rsp_err}, 32'd0);
            rst_n = 1'b1;
            #1;
            checkOutput("release_req_ready_low", {31'b0, req_ready}, 32'd0);
            tick();
            checkOutput("release_req_ready_high", {31'b0, req_ready}, 32'd1);

            // Back-to-back streaming with the consumer always ready.
            load_word(5'd1, words[0]);
            load_word(5'd2, words[1]);
            load_word(5'd3, words[2]);
            rsp_ready = 1'b1;
            for (int c = 0; c <= 3 + lat; c++) begin
                req_valid = (c < 3);
                req_addr  = 32'(4 * (c + 1));
                #1;
                if (c < 3) checkOutput("stream_req_ready", {31'b0, req_ready}, 32'd1);
                tick();
                if ((c + 1 - lat) >= 0 && (c + 1 - lat) < 3) begin
                    checkOutput("stream_rsp_valid", {31'b0, rsp_valid}, 32'd1);
                    checkOutput("stream_rsp_inst", rsp_inst, words[c + 1 - lat]);
                    checkOutput("stream_rsp_err", {30'b0, rsp_err}, 32'd0);
                end else begin
                    checkOutput("stream_idle_valid", {31'b0, rsp_valid}, 32'd0);
                end
            end

            // Back-pressure: exactly lat+1 credits, then ordered drain.
            rsp_ready = 1'b0;
            for (int c = 0; c <= lat + 2; c++) begin
                req_valid = 1'b1;
                req_addr  = 32'(4 * (c + 1));
                #1;
                checkOutput("bp_req_ready", {31'b0, req_ready}, (c < lat + 1) ? 32'd1 : 32'd0);
                tick();
            end
            req_valid = 1'b0;
            rsp_ready = 1'b1;
            #1;
            for (int j = 0; j <= lat; j++) begin
                checkOutput("bp_drain_valid", {31'b0, rsp_valid}, 32'd1);
                checkOutput("bp_drain_inst", rsp_inst, words[j]);
                tick();
            end
            checkOutput("bp_drain_empty", {31'b0, rsp_valid}, 32'd0);

            // Error flags.
            applyStimulus(32'h0000_0006);
            checkOutput("err_misaligned_valid", {31'b0, rsp_valid}, 32'd1);
            checkOutput("err_misaligned_err", {30'b0, rsp_err}, 32'd1);
            checkOutput("err_misaligned_inst", rsp_inst, 32'd0);
            applyStimulus(32'h0000_0080);
            checkOutput("err_range_err", {30'b0, rsp_err}, 32'd2);
            checkOutput("err_range_inst", rsp_inst, 32'd0);
            applyStimulus(32'h0000_0081);
            checkOutput("err_both_err", {30'b0, rsp_err}, 32'd3);
            checkOutput("err_both_inst", rsp_inst, 32'd0);
            applyStimulus(32'h1000_0004);
            checkOutput("err_high_bits_err", {30'b0, rsp_err}, 32'd2);
            applyStimulus(32'h0000_007c);
            checkOutput("last_word_valid", {31'b0, rsp_valid}, 32'd1);
            checkOutput("last_word_err", {30'b0, rsp_err}, 32'd0);
            tick();
            checkOutput("err_drain_empty", {31'b0, rsp_valid}, 32'd0);

            // Load blocks a coincident fetch; the next fetch sees the new word.
            ld_en     = 1'b1;
            ld_addr   = 5'd5;
            ld_data   = 32'hac640002;
            req_valid = 1'b1;
            req_addr  = 32'h14;
            #1;
            checkOutput("load_req_ready", {31'b0, req_ready}, 32'd0);
            tick();
            ld_en = 1'b0;
            #1;
            checkOutput("load_no_rsp", {31'b0, rsp_valid}, 32'd0);
            applyStimulus(32'h14);
            checkOutput("load_rsp_valid", {31'b0, rsp_valid}, 32'd1);
            checkOutput("load_rsp_inst", rsp_inst, 32'hac640002);
            tick();

            // Flush with two responses outstanding.
            rsp_ready = 1'b0;
            req_valid = 1'b1;
            req_addr  = 32'h8;
            tick();
            req_addr  = 32'hc;
            tick();
            req_addr  = 32'h4;
            flush     = 1'b1;
            #1;
            checkOutput("flush_req_ready", {31'b0, req_ready}, 32'd0);
            tick();
            flush     = 1'b0;
            req_valid = 1'b0;
            #1;
            checkOutput("flush_rsp_valid", {31'b0, rsp_valid}, 32'd0);
            repeat (lat + 1) begin
                tick();
                checkOutput("flush_stays_empty", {31'b0, rsp_valid}, 32'd0);
            end
            rsp_ready = 1'b1;
            applyStimulus(32'h4);
            checkOutput("post_flush_valid", {31'b0, rsp_valid}, 32'd1);
            checkOutput("post_flush_inst", rsp_inst, 32'h3c010001);
            tick();
            checkOutput("post_flush_alone", {31'b0, rsp_valid}, 32'd0);

            // Asynchronous reset with the FIFO full.
            rsp_ready = 1'b0;
            for (int c = 0; c <= lat; c++) begin
                req_valid = 1'b1;
                req_addr  = 32'h4;
                tick();
            end
            req_valid = 1'b0;
            repeat (lat) tick();
            checkOutput("full_rsp_valid", {31'b0, rsp_valid}, 32'd1);
            checkOutput("full_req_ready", {31'b0, req_ready}, 32'd0);
            #2;
            rst_n = 1'b0;
            #1;
            checkOutput("async_rst_valid", {31'b0, rsp_valid}, 32'd0);
            checkOutput("async_rst_ready", {31'b0, req_ready}, 32'd0);
            checkOutput("async_rst_inst", rsp_inst, 32'd0);
            tick();
            rst_n = 1'b1;
            tick();
            checkOutput("no_replay_valid", {31'b0, rsp_valid}, 32'd0);
            rsp_ready = 1'b1;
            applyStimulus(32'h4);
            checkOutput("after_rst_valid", {31'b0, rsp_valid}, 32'd1);
            checkOutput("after_rst_inst", rsp_inst, 32'h3c010001);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
